// File: rtl/slide_pkg.sv
// Shared types and constants for the slider interface and pot smoother.
package slide_pkg;

  localparam int unsigned POT_W  = 12;
  localparam int unsigned NUM_CH = 6;
  localparam int unsigned CH_W   = 3;

  typedef logic [POT_W-1:0] pot_t;

  localparam pot_t POT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    FILT,
    DONE
  } state_e;

  typedef enum logic [CH_W-1:0] {
    CH_LP  = 3'd0,
    CH_B1  = 3'd1,
    CH_B2  = 3'd2,
    CH_B3  = 3'd3,
    CH_HP  = 3'd4,
    CH_VOL = 3'd5
  } ch_e;

  function automatic pot_t abs_diff(input pot_t a, input pot_t b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/pot_smoother_if.sv
// Raw pot inputs from the slider interface and smoothed outputs toward the EQ/volume stages.
interface pot_smoother_if import slide_pkg::*; ();

  pot_t POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, POT_VOL;
  pot_t FLT_LP, FLT_B1, FLT_B2, FLT_B3, FLT_HP, FLT_VOL;
  logic upd;
  logic busy;

  modport master (
    output POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, POT_VOL,
    input  FLT_LP, FLT_B1, FLT_B2, FLT_B3, FLT_HP, FLT_VOL,
    input  upd, busy
  );

  modport slave (
    input  POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, POT_VOL,
    output FLT_LP, FLT_B1, FLT_B2, FLT_B3, FLT_HP, FLT_VOL,
    output upd, busy
  );

endinterface

// File: rtl/iir_lane.sv
// Shared combinational IIR step: next accumulator, filtered value and dead-band write decision.
module iir_lane import slide_pkg::*; #(
  parameter int unsigned SHIFT    = 3,
  parameter int unsigned DEADBAND = 4
) (
  input  logic [POT_W+SHIFT-1:0] acc_i,
  input  pot_t                   pot_i,
  input  pot_t                   flt_i,
  input  logic                   prime_i,
  output logic [POT_W+SHIFT-1:0] acc_new_c,
  output pot_t                   filt_c,
  output logic                   write_en_c
);

  localparam int unsigned ACC_W = POT_W + SHIFT;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [SUM_W-1:0] ACC_MAX = SUM_W'(POT_MAX) << SHIFT;
  localparam pot_t DB = POT_W'(DEADBAND);

  logic [SUM_W-1:0] sum;
  logic [ACC_W-1:0] acc_upd;
  pot_t             filt_upd;
  logic             at_rail;

  always_comb begin
    sum        = SUM_W'(acc_i) - SUM_W'(acc_i >> SHIFT) + SUM_W'(pot_i);
    acc_upd    = (sum > ACC_MAX) ? ACC_W'(ACC_MAX) : ACC_W'(sum);
    filt_upd   = POT_W'(acc_upd >> SHIFT);
    // Rails bypass the dead-band so 0 and full scale stay reachable.
    at_rail    = (filt_upd == '0) || (filt_upd == POT_MAX);
    acc_new_c  = acc_upd;
    filt_c     = filt_upd;
    write_en_c = (abs_diff(filt_upd, flt_i) >= DB) || (at_rail && (filt_upd != flt_i));
    if (prime_i) begin
      acc_new_c  = ACC_W'(pot_i) << SHIFT;
      filt_c     = pot_i;
      write_en_c = 1'b1;
    end
  end

endmodule

// File: rtl/pot_smoother.sv
// Time-multiplexed first-order IIR smoother with dead-band for the six slider pots.
module pot_smoother import slide_pkg::*; #(
  parameter int unsigned SHIFT    = 3,
  parameter int unsigned DEADBAND = 4,
  parameter int unsigned TICK_DIV = 1024
) (
  input  logic clk,
  input  logic rst_n,
  pot_smoother_if.slave bus
);

  localparam int unsigned ACC_W = POT_W + SHIFT;
  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  state_e           state_q, state_d;
  ch_e              ch_q, ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prime_q, prime_d;
  logic             chg_q, chg_d;
  logic             upd_q, upd_d;
  logic             busy_q, busy_d;
  logic             tick_c;

  logic [ACC_W-1:0] acc_q [NUM_CH];
  pot_t             flt_q [NUM_CH];
  pot_t             pot_arr [NUM_CH];

  pot_t             pot_sel;
  logic [ACC_W-1:0] lane_acc;
  pot_t             lane_filt;
  logic             lane_we;

  // Input mux: channel enum order matches the pass order.
  always_comb begin
    pot_arr[CH_LP]  = bus.POT_LP;
    pot_arr[CH_B1]  = bus.POT_B1;
    pot_arr[CH_B2]  = bus.POT_B2;
    pot_arr[CH_B3]  = bus.POT_B3;
    pot_arr[CH_HP]  = bus.POT_HP;
    pot_arr[CH_VOL] = bus.POT_VOL;
    pot_sel         = pot_arr[ch_q];
  end

  iir_lane #(
    .SHIFT    (SHIFT),
    .DEADBAND (DEADBAND)
  ) u_lane (
    .acc_i      (acc_q[ch_q]),
    .pot_i      (pot_sel),
    .flt_i      (flt_q[ch_q]),
    .prime_i    (prime_q),
    .acc_new_c  (lane_acc),
    .filt_c     (lane_filt),
    .write_en_c (lane_we)
  );

  // Free-running pass timer; a tick while busy is simply not acted on.
  always_comb begin
    tick_c = (cnt_q == CNT_LAST);
    cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
  end

  // Pass sequencer and pass-level flags.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    prime_d = prime_q;
    chg_d   = chg_q;
    upd_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick_c) begin
          state_d = FILT;
          ch_d    = CH_LP;
          chg_d   = 1'b0;
        end
      end
      FILT: begin
        chg_d = chg_q | lane_we;
        if (ch_q == CH_VOL) begin
          state_d = DONE;
          upd_d   = chg_d;
        end else begin
          ch_d = ch_e'(ch_q + CH_W'(1));
        end
      end
      DONE: begin
        prime_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= CH_LP;
      cnt_q   <= '0;
      prime_q <= 1'b1;
      chg_q   <= 1'b0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      prime_q <= prime_d;
      chg_q   <= chg_d;
      upd_q   <= upd_d;
      busy_q  <= busy_d;
    end
  end

  // Per-channel state commits at the end of that channel's FILT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        acc_q[i] <= '0;
        flt_q[i] <= '0;
      end
    end else if (state_q == FILT) begin
      acc_q[ch_q] <= lane_acc;
      if (lane_we) begin
        flt_q[ch_q] <= lane_filt;
      end
    end
  end

  assign bus.FLT_LP  = flt_q[CH_LP];
  assign bus.FLT_B1  = flt_q[CH_B1];
  assign bus.FLT_B2  = flt_q[CH_B2];
  assign bus.FLT_B3  = flt_q[CH_B3];
  assign bus.FLT_HP  = flt_q[CH_HP];
  assign bus.FLT_VOL = flt_q[CH_VOL];
  assign bus.upd     = upd_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_pot_smoother.sv
// Bench for pot_smoother: hand vectors, corner sequences and random passes against an arithmetic model.
module tb_pot_smoother;

  localparam int TD = 16;
  localparam int S  = 3;
  localparam int DB = 4;

  typedef logic [5:0][11:0] potv_t;

  typedef struct {
    potv_t pot;
    potv_t flt;
    bit    upd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pot_smoother_if bus ();

  pot_smoother #(
    .SHIFT    (S),
    .DEADBAND (DB),
    .TICK_DIV (TD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  int m_acc [6];
  int m_flt [6];
  bit m_prime;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic potv_t mk(input int lp, input int b1, input int b2,
                               input int b3, input int hp, input int vol);
    potv_t p;
    p[0] = 12'(lp); p[1] = 12'(b1); p[2] = 12'(b2);
    p[3] = 12'(b3); p[4] = 12'(hp); p[5] = 12'(vol);
    return p;
  endfunction

  task automatic set_pots(input potv_t p);
    bus.POT_LP = p[0]; bus.POT_B1 = p[1]; bus.POT_B2 = p[2];
    bus.POT_B3 = p[3]; bus.POT_HP = p[4]; bus.POT_VOL = p[5];
  endtask

  function automatic potv_t get_flt();
    potv_t f;
    f[0] = bus.FLT_LP; f[1] = bus.FLT_B1; f[2] = bus.FLT_B2;
    f[3] = bus.FLT_B3; f[4] = bus.FLT_HP; f[5] = bus.FLT_VOL;
    return f;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 6; c++) begin
      m_acc[c] = 0;
      m_flt[c] = 0;
    end
    m_prime = 1'b1;
  endfunction

  // One filter pass computed directly from the smoothing rules with integer arithmetic.
  function automatic bit model_pass(input potv_t p);
    bit chg = 1'b0;
    int scale = 1 << S;
    for (int c = 0; c < 6; c++) begin
      int pv = int'(p[c]);
      if (m_prime) begin
        m_acc[c] = pv * scale;
        m_flt[c] = pv;
        chg = 1'b1;
      end else begin
        int a = m_acc[c] - m_acc[c] / scale + pv;
        int f;
        int d;
        if (a > 4095 * scale) a = 4095 * scale;
        m_acc[c] = a;
        f = a / scale;
        d = (f > m_flt[c]) ? f - m_flt[c] : m_flt[c] - f;
        if (d >= DB || ((f == 0 || f == 4095) && f != m_flt[c])) begin
          m_flt[c] = f;
          chg = 1'b1;
        end
      end
    end
    m_prime = 1'b0;
    return chg;
  endfunction

  task automatic do_reset(input potv_t p);
    set_pots(p);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for the next pass with p applied; returns final FLT and upd seen in the DONE cycle.
  task automatic run_pass(input string name, input potv_t p, output potv_t f, output bit u);
    bit found = 1'b0;
    bit early = 1'b0;
    set_pots(p);
    f = '0;
    u = 1'b0;
    for (int i = 0; i < 2 * TD + 4; i++) begin
      step();
      if (bus.busy) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      chk({name, "_busy_timeout"}, 0, 1);
      return;
    end
    if (bus.upd) early = 1'b1;
    repeat (5) begin
      step();
      if (bus.upd) early = 1'b1;
    end
    chk({name, "_upd_early"}, int'(early), 0);
    step();
    u = bus.upd;
    chk({name, "_busy_done"}, int'(bus.busy), 1);
    step();
    chk({name, "_busy_end"}, int'(bus.busy), 0);
    chk({name, "_upd_pulse"}, int'(bus.upd), 0);
    f = get_flt();
  endtask

  task automatic pass_vs_model(input string name, input potv_t p, output potv_t f);
    bit u;
    bit exp_u;
    run_pass(name, p, f, u);
    exp_u = model_pass(p);
    for (int c = 0; c < 6; c++)
      chk($sformatf("%s_flt%0d", name, c), int'(f[c]), m_flt[c]);
    chk({name, "_upd"}, int'(u), int'(exp_u));
  endtask

  vec_t  vecs [4];
  potv_t f;
  potv_t cur;
  bit    u;
  bit    flag;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{pot: mk(1000, 0, 1000, 0, 4090, 4095),
                flt: mk(1000, 0, 1000, 0, 4090, 4095), upd: 1'b1};
    vecs[1] = '{pot: mk(1000, 800, 1002, 0, 4095, 4095),
                flt: mk(1000, 100, 1000, 0, 4090, 4095), upd: 1'b1};
    vecs[2] = '{pot: mk(1000, 800, 1002, 0, 4095, 4095),
                flt: mk(1000, 187, 1000, 0, 4090, 4095), upd: 1'b1};
    vecs[3] = '{pot: mk(1000, 800, 1002, 0, 4095, 4095),
                flt: mk(1000, 264, 1000, 0, 4090, 4095), upd: 1'b1};

    // Reset state and first-pass timing with all pots at zero.
    do_reset('0);
    #1;
    f = get_flt();
    for (int c = 0; c < 6; c++) chk($sformatf("rst_flt%0d", c), int'(f[c]), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_upd", int'(bus.upd), 0);
    flag = 1'b0;
    for (int n = 1; n <= TD - 1; n++) begin
      step();
      if (bus.busy || bus.upd) flag = 1'b1;
    end
    chk("idle_quiet", int'(flag), 0);
    step();
    chk("first_busy", int'(bus.busy), 1);
    flag = 1'b0;
    for (int n = TD + 1; n <= TD + 5; n++) begin
      step();
      if (bus.upd) flag = 1'b1;
    end
    chk("first_upd_early", int'(flag), 0);
    step();
    chk("first_upd", int'(bus.upd), 1);
    step();
    chk("first_upd_drop", int'(bus.upd), 0);
    chk("first_busy_drop", int'(bus.busy), 0);

    // Priming and step response from the hand vectors.
    do_reset(vecs[0].pot);
    for (int v = 0; v < 4; v++) begin
      run_pass($sformatf("vec%0d", v), vecs[v].pot, f, u);
      void'(model_pass(vecs[v].pot));
      for (int c = 0; c < 6; c++)
        chk($sformatf("vec%0d_flt%0d", v, c), int'(f[c]), int'(vecs[v].flt[c]));
      chk($sformatf("vec%0d_upd", v), int'(u), int'(vecs[v].upd));
    end

    // Dead-band: a 2-LSB nudge on B2 never moves its output or raises upd.
    cur = mk(500, 600, 1000, 700, 800, 900);
    do_reset(cur);
    pass_vs_model("db_prime", cur, f);
    cur[2] = 12'd1002;
    for (int k = 0; k < 6; k++) begin
      run_pass($sformatf("db%0d", k), cur, f, u);
      void'(model_pass(cur));
      chk($sformatf("db%0d_flt_b2", k), int'(f[2]), 1000);
      chk($sformatf("db%0d_upd", k), int'(u), 0);
    end

    // Rail reach: HP creeps from 4090 to exactly 4095.
    cur = mk(0, 0, 0, 0, 4090, 0);
    do_reset(cur);
    pass_vs_model("rail_prime", cur, f);
    cur[4] = 12'd4095;
    for (int k = 0; k < 60; k++) begin
      pass_vs_model($sformatf("rail%0d", k), cur, f);
      if (f[4] == 12'd4095) break;
    end
    chk("rail_reach", int'(f[4]), 4095);

    // Reset during channel B3 of a pass, then a prime pass follows.
    cur = mk(123, 456, 789, 1011, 1213, 1415);
    set_pots(cur);
    flag = 1'b0;
    for (int i = 0; i < 2 * TD + 4; i++) begin
      step();
      if (bus.busy) begin
        flag = 1'b1;
        break;
      end
    end
    chk("midrst_busy_seen", int'(flag), 1);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    f = get_flt();
    for (int c = 0; c < 6; c++) chk($sformatf("midrst_flt%0d", c), int'(f[c]), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_upd", int'(bus.upd), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cur = mk(3000, 17, 4095, 0, 2048, 999);
    run_pass("post_rst", cur, f, u);
    void'(model_pass(cur));
    for (int c = 0; c < 6; c++)
      chk($sformatf("post_rst_flt%0d", c), int'(f[c]), int'(cur[c]));
    chk("post_rst_upd", int'(u), 1);

    // Random passes against the model.
    cur = '0;
    do_reset(cur);
    for (int k = 0; k < 150; k++) begin
      int mode = int'($urandom_range(0, 3));
      for (int c = 0; c < 6; c++) begin
        int v = int'(cur[c]);
        case (mode)
          0: v = int'($urandom_range(0, 4095));
          1: begin
            v = v + int'($urandom_range(0, 16)) - 8;
            if (v < 0) v = 0;
            if (v > 4095) v = 4095;
          end
          2: v = ($urandom_range(0, 1) == 1) ? 4095 : 0;
          default: ;
        endcase
        cur[c] = 12'(v);
      end
      pass_vs_model($sformatf("rnd%0d", k), cur, f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
